// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings, coin values and the credit-stage states.
package vend_pkg;

  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_25  = 2'b10;
  localparam logic [1:0] COIN_100 = 2'b11;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_ARMED  = 2'd1,
    ST_PAYOUT = 2'd2
  } state_e;

  // Face value in cents of a coin code.
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_25: return 8'd25;
      default: return 8'd100;
    endcase
  endfunction

endpackage

// File: rtl/coin_credit_unit_if.sv
// Coin mechanism / controller / hopper signal bundle of the credit stage.
interface coin_credit_unit_if #(
  parameter int CREDIT_W = 8
) ();
  logic                coin_valid;
  logic [1:0]          coin_code;
  logic                cancel;
  logic                change_returned;
  logic                coin_inserted;
  logic                coin_reject;
  logic                payout_valid;
  logic [1:0]          payout_code;
  logic                payout_ready;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  // Credit stage side.
  modport slave (
    input  coin_valid, coin_code, cancel, change_returned, payout_ready,
    output coin_inserted, coin_reject, payout_valid, payout_code, credit, busy
  );

  // Environment side (coin mechanism, controller and hopper).
  modport master (
    output coin_valid, coin_code, cancel, change_returned, payout_ready,
    input  coin_inserted, coin_reject, payout_valid, payout_code, credit, busy
  );
endinterface

// File: rtl/payout_selector.sv
// Greedy change selection: largest of 25/10/5 that fits in the remaining credit.
module payout_selector
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [1:0]          code_o,
  output logic [CREDIT_W-1:0] value_o
);

  // Pick the coin; 100 is never paid out, and credit is always a multiple of 5.
  always_comb begin
    if (credit_i >= CREDIT_W'(25))      code_o = COIN_25;
    else if (credit_i >= CREDIT_W'(10)) code_o = COIN_10;
    else                                code_o = COIN_5;
  end

  assign value_o = CREDIT_W'(coin_value(code_o));

endmodule

// File: rtl/coin_credit_unit.sv
// Credit accumulation, purchase arming and change/refund payout ahead of the vending controller.
module coin_credit_unit
  import vend_pkg::*;
#(
  parameter int PRICE      = 75,
  parameter int MAX_CREDIT = 200,
  parameter int CREDIT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  coin_credit_unit_if.slave bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   PRICE_W = {1'b0, PRICE_C};
  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                coin_reject_q;
  logic                payout_valid_q;
  logic [1:0]          payout_code_q;
  logic [CREDIT_W-1:0] payout_value_q;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                handshake;
  logic [CREDIT_W-1:0] credit_after_pay;
  logic [CREDIT_W-1:0] sel_credit;
  logic [1:0]          sel_code;
  logic [CREDIT_W-1:0] sel_value;

  // One bit of headroom so an overflowing coin is caught before it wraps.
  assign coin_val  = CREDIT_W'(coin_value(bus.coin_code));
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};

  // On a handshake the next coin is chosen from what remains after this one,
  // so consecutive coins can go out on consecutive cycles.
  assign handshake        = payout_valid_q & bus.payout_ready;
  assign credit_after_pay = credit_q - payout_value_q;
  assign sel_credit       = handshake ? credit_after_pay : credit_q;

  payout_selector #(.CREDIT_W(CREDIT_W)) u_payout_selector (
    .credit_i (sel_credit),
    .code_o   (sel_code),
    .value_o  (sel_value)
  );

  // Credit FSM with registered reject and hopper request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ACCUM;
      credit_q       <= '0;
      coin_reject_q  <= 1'b0;
      payout_valid_q <= 1'b0;
      payout_code_q  <= COIN_5;
      payout_value_q <= '0;
    end else begin
      coin_reject_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (bus.cancel) begin
            // Cancel wins over a simultaneous coin; that coin goes to the chute.
            coin_reject_q <= bus.coin_valid;
            if (credit_q != '0) state_q <= ST_PAYOUT;
          end else if (bus.coin_valid) begin
            if (coin_sum > MAX_W) begin
              coin_reject_q <= 1'b1;
            end else begin
              credit_q <= coin_sum[CREDIT_W-1:0];
              if (coin_sum >= PRICE_W) state_q <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          // No abort once armed: cancel is ignored and coins are refused.
          coin_reject_q <= bus.coin_valid;
          if (bus.change_returned) begin
            credit_q <= credit_q - PRICE_C;
            state_q  <= (credit_q == PRICE_C) ? ST_ACCUM : ST_PAYOUT;
          end
        end
        ST_PAYOUT: begin
          coin_reject_q <= bus.coin_valid;
          if (!payout_valid_q) begin
            payout_valid_q <= 1'b1;
            payout_code_q  <= sel_code;
            payout_value_q <= sel_value;
          end else if (bus.payout_ready) begin
            credit_q <= credit_after_pay;
            if (credit_after_pay == '0) begin
              payout_valid_q <= 1'b0;
              state_q        <= ST_ACCUM;
            end else begin
              payout_code_q  <= sel_code;
              payout_value_q <= sel_value;
            end
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign bus.coin_inserted = (state_q == ST_ARMED);
  assign bus.busy          = (state_q == ST_PAYOUT);
  assign bus.coin_reject   = coin_reject_q;
  assign bus.payout_valid  = payout_valid_q;
  assign bus.payout_code   = payout_code_q;
  assign bus.credit        = credit_q;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Bench for coin_credit_unit: scoreboard for rejects and hopper transfers plus directed credit checks.
module tb_coin_credit_unit;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coin_credit_unit_if #(.CREDIT_W(8)) bus ();
  coin_credit_unit_if #(.CREDIT_W(8)) bus2 ();

  coin_credit_unit #(.PRICE(75), .MAX_CREDIT(200), .CREDIT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  coin_credit_unit #(.PRICE(200), .MAX_CREDIT(200), .CREDIT_W(8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  logic [7:0] sel_in;
  logic [1:0] sel_code;
  logic [7:0] sel_value;
  payout_selector #(.CREDIT_W(8)) u_sel (
    .credit_i(sel_in), .code_o(sel_code), .value_o(sel_value)
  );

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_pay_q[$];
  int         exp_rej_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic insert(input logic [1:0] code);
    bus.coin_valid = 1'b1;
    bus.coin_code  = code;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic insert2(input logic [1:0] code);
    bus2.coin_valid = 1'b1;
    bus2.coin_code  = code;
    tick();
    bus2.coin_valid = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  task automatic pulse_change();
    bus.change_returned = 1'b1;
    tick();
    bus.change_returned = 1'b0;
  endtask

  // Monitor: pops expected rejects and hopper transfers as the DUT presents them.
  logic       prev_stall = 1'b0;
  logic [1:0] prev_code  = 2'b00;
  always @(negedge clk) begin
    int e;
    logic [1:0] ec;
    if (!reset && prev_stall) begin
      check("hold_valid", 32'(bus.payout_valid), 32'd1);
      check("hold_code", 32'(bus.payout_code), 32'(prev_code));
    end
    if (bus.coin_reject) begin
      if (exp_rej_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL reject_unexpected actual=1 required=0 credit=%0d", bus.credit);
      end else begin
        e = exp_rej_q.pop_front();
        check("reject_credit", 32'(bus.credit), 32'(e));
      end
    end
    if (bus.payout_valid && bus.payout_ready) begin
      if (exp_pay_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL payout_unexpected actual=%0d required=none", bus.payout_code);
      end else begin
        ec = exp_pay_q.pop_front();
        check("payout_code", 32'(bus.payout_code), 32'(ec));
      end
    end
    prev_stall = !reset && bus.payout_valid && !bus.payout_ready;
    prev_code  = bus.payout_code;
  end

  typedef struct { int credit; int code; int value; } sel_vec_t;
  sel_vec_t sel_vecs[7] = '{
    '{5, 0, 5}, '{10, 1, 10}, '{15, 1, 10}, '{20, 1, 10},
    '{25, 2, 25}, '{40, 2, 25}, '{200, 2, 25}
  };

  initial begin
    reset = 1'b1;
    bus.coin_valid = 0; bus.coin_code = 0; bus.cancel = 0;
    bus.change_returned = 0; bus.payout_ready = 0;
    bus2.coin_valid = 0; bus2.coin_code = 0; bus2.cancel = 0;
    bus2.change_returned = 0; bus2.payout_ready = 0;
    sel_in = 8'd0;

    // Standalone greedy selector.
    foreach (sel_vecs[i]) begin
      sel_in = 8'(sel_vecs[i].credit);
      #1;
      check($sformatf("sel_code_%0d", sel_vecs[i].credit), 32'(sel_code), 32'(sel_vecs[i].code));
      check($sformatf("sel_value_%0d", sel_vecs[i].credit), 32'(sel_value), 32'(sel_vecs[i].value));
    end

    #12;
    check("rst_credit", 32'(bus.credit), 0);
    check("rst_inserted", 32'(bus.coin_inserted), 0);
    check("rst_reject", 32'(bus.coin_reject), 0);
    check("rst_pvalid", 32'(bus.payout_valid), 0);
    check("rst_pcode", 32'(bus.payout_code), 0);
    check("rst_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;

    // Three quarters arm the purchase.
    insert(COIN_25); check("c25_credit", 32'(bus.credit), 25); check("c25_ins", 32'(bus.coin_inserted), 0);
    insert(COIN_25); check("c50_credit", 32'(bus.credit), 50); check("c50_ins", 32'(bus.coin_inserted), 0);
    insert(COIN_25); check("c75_credit", 32'(bus.credit), 75); check("c75_ins", 32'(bus.coin_inserted), 1);
    check("c75_busy", 32'(bus.busy), 0);
    tick(); check("c75_pvalid", 32'(bus.payout_valid), 0);

    // Exact credit: vend without change.
    pulse_change();
    check("exact_credit", 32'(bus.credit), 0);
    check("exact_ins", 32'(bus.coin_inserted), 0);
    check("exact_busy", 32'(bus.busy), 0);

    // Dollar coin, reject while armed, then 25c change.
    insert(COIN_100); check("c100_credit", 32'(bus.credit), 100); check("c100_ins", 32'(bus.coin_inserted), 1);
    exp_rej_q.push_back(100);
    insert(COIN_100); check("armed_rej_credit", 32'(bus.credit), 100);
    tick(); check("armed_rej_drop", 32'(bus.coin_reject), 0);
    exp_pay_q.push_back(COIN_25);
    pulse_change();
    check("chg_credit", 32'(bus.credit), 25);
    check("chg_busy", 32'(bus.busy), 1);
    check("chg_ins", 32'(bus.coin_inserted), 0);
    check("chg_pvalid", 32'(bus.payout_valid), 0);
    bus.payout_ready = 1'b1;
    tick(); check("chg_pvalid_rise", 32'(bus.payout_valid), 1); check("chg_pcode", 32'(bus.payout_code), 32'(COIN_25));
    tick();
    check("chg_done_credit", 32'(bus.credit), 0);
    check("chg_done_pvalid", 32'(bus.payout_valid), 0);
    check("chg_done_busy", 32'(bus.busy), 0);
    bus.payout_ready = 1'b0;

    // Refund of 40c with the hopper stalled for three cycles and a coin during payout.
    insert(COIN_25); insert(COIN_10); insert(COIN_5);
    check("ref_credit", 32'(bus.credit), 40);
    pulse_cancel();
    check("ref_busy", 32'(bus.busy), 1);
    tick(); check("ref_pvalid", 32'(bus.payout_valid), 1); check("ref_pcode", 32'(bus.payout_code), 32'(COIN_25));
    exp_rej_q.push_back(40);
    insert(COIN_5);
    tick();
    exp_pay_q.push_back(COIN_25); exp_pay_q.push_back(COIN_10); exp_pay_q.push_back(COIN_5);
    bus.payout_ready = 1'b1;
    tick(); check("ref_credit_15", 32'(bus.credit), 15);
    tick(); check("ref_credit_5", 32'(bus.credit), 5);
    tick(); check("ref_credit_0", 32'(bus.credit), 0); check("ref_pvalid_drop", 32'(bus.payout_valid), 0);
    check("ref_busy_drop", 32'(bus.busy), 0);
    bus.payout_ready = 1'b0;

    // Cancel with no credit does nothing.
    pulse_cancel(); check("cancel0_busy", 32'(bus.busy), 0);
    tick(); check("cancel0_pvalid", 32'(bus.payout_valid), 0);

    // Coin and cancel together: coin rejected, existing 10c refunded.
    insert(COIN_10);
    exp_rej_q.push_back(10);
    exp_pay_q.push_back(COIN_10);
    bus.payout_ready = 1'b1;
    bus.cancel = 1'b1;
    insert(COIN_100);
    bus.cancel = 1'b0;
    check("both_credit", 32'(bus.credit), 10); check("both_busy", 32'(bus.busy), 1);
    tick(); check("both_pcode", 32'(bus.payout_code), 32'(COIN_10));
    tick(); check("both_credit0", 32'(bus.credit), 0);
    bus.payout_ready = 1'b0;

    // Overflow boundary on the PRICE = MAX_CREDIT = 200 instance.
    insert2(COIN_100); insert2(COIN_25); insert2(COIN_25);
    check("ovf_credit150", 32'(bus2.credit), 150);
    insert2(COIN_100);
    check("ovf_reject", 32'(bus2.coin_reject), 1); check("ovf_credit", 32'(bus2.credit), 150);
    tick(); check("ovf_reject_drop", 32'(bus2.coin_reject), 0);
    insert2(COIN_25); check("ovf_credit175", 32'(bus2.credit), 175); check("ovf_ins175", 32'(bus2.coin_inserted), 0);
    insert2(COIN_25); check("ovf_credit200", 32'(bus2.credit), 200); check("ovf_ins200", 32'(bus2.coin_inserted), 1);
    check("ovf_reject_200", 32'(bus2.coin_reject), 0);

    // Asynchronous reset in the middle of a 35c refund.
    insert(COIN_25); insert(COIN_10);
    pulse_cancel();
    tick(); check("mid_pvalid", 32'(bus.payout_valid), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_pvalid", 32'(bus.payout_valid), 0);
    check("mid_rst_credit", 32'(bus.credit), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;
    insert(COIN_5); check("post_rst_credit", 32'(bus.credit), 5);

    tick(2);
    check("rej_queue_left", 32'(exp_rej_q.size()), 0);
    check("pay_queue_left", 32'(exp_pay_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
